// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg: shared state type and constants for the core memory arbiter
package core_mem_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, GRANT_INSTR, GRANT_DATA} ArbState_t;
   localparam int DEFAULT_MAX_DATA_BURST = 4;
   localparam logic [1:0] INSTR_BYTESEL = 2'b11;
   localparam logic INSTR_WR_EN = 1'b0;
endpackage

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: arbitrates instruction fetch and data ports onto one shared memory/IO bus
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_BURST = DEFAULT_MAX_DATA_BURST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:1] instr_m_addr,
   input  logic        instr_m_access,
   output logic        instr_m_ack,
   output logic [15:0] instr_m_data_in,
   input  logic [19:1] data_m_addr,
   input  logic [15:0] data_m_data_out,
   input  logic        data_m_access,
   input  logic        data_m_wr_en,
   input  logic [1:0]  data_m_bytesel,
   input  logic        d_io,
   output logic        data_m_ack,
   output logic [15:0] data_m_data_in,
   output logic [19:1] q_m_addr,
   output logic [15:0] q_m_data_out,
   output logic        q_m_access,
   output logic        q_m_wr_en,
   output logic [1:0]  q_m_bytesel,
   output logic        q_io,
   input  logic [15:0] q_m_data_in,
   input  logic        q_m_ack
);
   localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);
   ArbState_t   r_state;
   logic [3:0]  r_burst_cnt;
   logic [15:0] r_instr_grants;
   logic [15:0] r_data_grants;
   logic        w_gi;
   logic        w_gd;
   logic        w_burst_full;
   logic        w_instr_due;
   assign w_gi         = r_state == GRANT_INSTR;
   assign w_gd         = r_state == GRANT_DATA;
   assign w_burst_full = r_burst_cnt == BURST_MAX;
   assign w_instr_due  = instr_m_access && w_burst_full;
   // Data wins unless the waiting fetch has already seen a full burst of data grants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= IDLE;
         r_burst_cnt    <= '0;
         r_instr_grants <= '0;
         r_data_grants  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (data_m_access && !w_instr_due) begin
                  r_state       <= GRANT_DATA;
                  r_data_grants <= r_data_grants + 16'd1;
                  r_burst_cnt   <= !instr_m_access ? 4'd0 : w_burst_full ? r_burst_cnt : r_burst_cnt + 4'd1;
               end else if (instr_m_access) begin
                  r_state        <= GRANT_INSTR;
                  r_instr_grants <= r_instr_grants + 16'd1;
                  r_burst_cnt    <= '0;
               end else begin
                  r_burst_cnt <= '0;
               end
            end
            default: if (q_m_ack) r_state <= IDLE;
         endcase
      end
   end
   assign q_m_access      = w_gi ? instr_m_access : w_gd & data_m_access;
   assign q_m_addr        = w_gi ? instr_m_addr : w_gd ? data_m_addr : '0;
   assign q_m_data_out    = w_gd ? data_m_data_out : '0;
   assign q_m_wr_en       = w_gi ? INSTR_WR_EN : w_gd & data_m_wr_en;
   assign q_m_bytesel     = w_gi ? INSTR_BYTESEL : w_gd ? data_m_bytesel : 2'b00;
   assign q_io            = w_gd & d_io;
   assign instr_m_ack     = w_gi & q_m_ack;
   assign data_m_ack      = w_gd & q_m_ack;
   assign instr_m_data_in = instr_m_ack ? q_m_data_in : '0;
   assign data_m_data_in  = data_m_ack ? q_m_data_in : '0;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: scoreboard bench for core_mem_arbiter with requester and memory models
module tb_core_mem_arbiter;
   import core_mem_arbiter_pkg::*;
   typedef struct {
      bit          is_d;
      logic [18:0] addr;
      logic [15:0] wdata;
      logic        wr;
      logic [1:0]  bsel;
      logic        io;
   } req_t;
   logic        clk = 0;
   logic        reset;
   logic [19:1] instr_m_addr;
   logic        instr_m_access;
   logic        instr_m_ack;
   logic [15:0] instr_m_data_in;
   logic [19:1] data_m_addr;
   logic [15:0] data_m_data_out;
   logic        data_m_access;
   logic        data_m_wr_en;
   logic [1:0]  data_m_bytesel;
   logic        d_io;
   logic        data_m_ack;
   logic [15:0] data_m_data_in;
   logic [19:1] q_m_addr;
   logic [15:0] q_m_data_out;
   logic        q_m_access;
   logic        q_m_wr_en;
   logic [1:0]  q_m_bytesel;
   logic        q_io;
   logic [15:0] q_m_data_in;
   logic        q_m_ack;
   logic        r_mack = 0;
   logic [15:0] r_mdata = 0;
   logic        spur = 0;
   logic [15:0] mem_key = 16'h1234;
   int          mem_lat = 0;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          d_raise_cyc = 0;
   int          d_ack_cyc = 0;
   int          n_d_acks = 0;
   int          n_i_acks = 0;
   req_t        dq[$];
   req_t        iq[$];
   req_t        sb[$];
   core_mem_arbiter #(.MAX_DATA_BURST(4)) dut (
      .clk(clk), .reset(reset),
      .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
      .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
      .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
      .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
      .data_m_bytesel(data_m_bytesel), .d_io(d_io),
      .data_m_ack(data_m_ack), .data_m_data_in(data_m_data_in),
      .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
      .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel), .q_io(q_io),
      .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack)
   );
   assign q_m_ack     = r_mack | spur;
   assign q_m_data_in = spur ? 16'hDEAD : r_mdata;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
      end
   endtask
   function automatic logic [15:0] mem_f(input logic [18:0] a);
      return a[15:0] ^ mem_key;
   endfunction
   function automatic req_t mk_d(input logic [18:0] a, input logic [15:0] wd, input logic wr,
                                 input logic [1:0] bs, input logic io);
      req_t r;
      r.is_d = 1; r.addr = a; r.wdata = wd; r.wr = wr; r.bsel = bs; r.io = io;
      return r;
   endfunction
   function automatic req_t mk_i(input logic [18:0] a);
      req_t r;
      r.is_d = 0; r.addr = a; r.wdata = 0; r.wr = 0; r.bsel = 2'b11; r.io = 0;
      return r;
   endfunction
   // memory model: acks mem_lat cycles after it first sees q_m_access
   initial begin
      int wc = 0;
      forever begin
         @(posedge clk);
         #2;
         if (r_mack) begin
            r_mack = 0; r_mdata = 0; wc = 0;
         end else if (q_m_access) begin
            if (wc >= mem_lat) begin
               r_mack = 1; r_mdata = mem_f(q_m_addr);
            end else wc++;
         end else wc = 0;
      end
   end
   initial begin
      req_t r;
      int n;
      data_m_access = 0; data_m_addr = 0; data_m_data_out = 0;
      data_m_wr_en = 0; data_m_bytesel = 0; d_io = 0;
      forever begin
         if (dq.size() > 0 && !reset) begin
            r = dq.pop_front();
            data_m_addr = r.addr; data_m_data_out = r.wdata; data_m_wr_en = r.wr;
            data_m_bytesel = r.bsel; d_io = r.io; data_m_access = 1;
            d_raise_cyc = cyc;
            n = 0;
            do begin @(negedge clk); n++; end while (!data_m_ack && !reset && n < 300);
            if (n >= 300) chk("d_req_timeout", n, 0);
            @(posedge clk);
            #1;
            data_m_access = 0; data_m_addr = 0; data_m_data_out = 0;
            data_m_wr_en = 0; data_m_bytesel = 0; d_io = 0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   end
   initial begin
      req_t r;
      int n;
      instr_m_access = 0; instr_m_addr = 0;
      forever begin
         if (iq.size() > 0 && !reset) begin
            r = iq.pop_front();
            instr_m_addr = r.addr; instr_m_access = 1;
            n = 0;
            do begin @(negedge clk); n++; end while (!instr_m_ack && !reset && n < 300);
            if (n >= 300) chk("i_req_timeout", n, 0);
            @(posedge clk);
            #1;
            instr_m_access = 0; instr_m_addr = 0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   end
   // bus owner is always the head of the scoreboard
   always @(negedge clk) begin
      req_t e;
      if (!reset) begin
         if (q_m_access) begin
            if (sb.size() == 0) chk("q_unexpected", sb.size(), 1);
            else begin
               e = sb[0];
               chk("q_addr", q_m_addr, e.addr);
               chk("q_wr_en", q_m_wr_en, e.wr);
               chk("q_bytesel", q_m_bytesel, e.bsel);
               chk("q_io", q_io, e.io);
               chk("q_wdata", q_m_data_out, e.wdata);
            end
         end
         if (instr_m_ack || data_m_ack) begin
            if (data_m_ack) begin d_ack_cyc = cyc; n_d_acks++; end
            else n_i_acks++;
            if (sb.size() == 0) chk("ack_unexpected", sb.size(), 1);
            else begin
               e = sb.pop_front();
               chk("ack_port", data_m_ack, e.is_d);
               chk("ack_other", e.is_d ? instr_m_ack : data_m_ack, 0);
               chk("ack_data", e.is_d ? data_m_data_in : instr_m_data_in, mem_f(e.addr));
            end
         end else chk("noack_rdata", {instr_m_data_in, data_m_data_in}, 0);
      end
   end
   task automatic wait_drain();
      int n = 0;
      while ((dq.size() > 0 || iq.size() > 0 || sb.size() > 0 || data_m_access || instr_m_access) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", n < 500, 1);
      repeat (2) @(negedge clk);
   endtask
   initial begin
      int di, ii, n, d_base, i_base;
      req_t dr[10];
      req_t ir[2];
      reset = 1;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {q_m_access, q_m_wr_en, q_io, q_m_bytesel}, 0);
      chk("rst_addr", q_m_addr, 0);
      chk("rst_wdata", q_m_data_out, 0);
      chk("rst_acks", {instr_m_ack, data_m_ack, instr_m_data_in, data_m_data_in}, 0);
      @(posedge clk);
      #1;
      reset = 0;
      mem_key = 16'hBEEF ^ 16'h2345;
      mem_lat = 3;
      @(negedge clk);
      iq.push_back(mk_i(19'h12345));
      sb.push_back(mk_i(19'h12345));
      wait_drain();
      mem_key = 16'h1234;
      mem_lat = 0;
      @(negedge clk);
      dq.push_back(mk_d(19'h00400, 16'hA55A, 1, 2'b01, 1));
      sb.push_back(mk_d(19'h00400, 16'hA55A, 1, 2'b01, 1));
      wait_drain();
      chk("d_ack_edges", d_ack_cyc + 1 - d_raise_cyc, 2);
      mem_lat = 1;
      @(negedge clk);
      dq.push_back(mk_d(19'h01000, 16'h1111, 0, 2'b11, 0));
      iq.push_back(mk_i(19'h02000));
      sb.push_back(mk_d(19'h01000, 16'h1111, 0, 2'b11, 0));
      sb.push_back(mk_i(19'h02000));
      wait_drain();
      mem_lat = 0;
      for (int k = 0; k < 10; k++) dr[k] = mk_d(19'h30000 + 19'(k), 16'(k * 16'h0101), k[0], 2'b10, k[1]);
      for (int j = 0; j < 2; j++) ir[j] = mk_i(19'h40000 + 19'(j));
      @(negedge clk);
      for (int k = 0; k < 10; k++) dq.push_back(dr[k]);
      for (int j = 0; j < 2; j++) iq.push_back(ir[j]);
      di = 0; ii = 0;
      for (int g = 0; g < 12; g++) begin
         if (g % 5 == 4) sb.push_back(ir[ii++]);
         else sb.push_back(dr[di++]);
      end
      wait_drain();
      @(posedge clk);
      #3;
      spur = 1;
      @(negedge clk);
      chk("spur_acks", {instr_m_ack, data_m_ack}, 0);
      chk("spur_q_access", q_m_access, 0);
      @(posedge clk);
      #1;
      spur = 0;
      @(negedge clk);
      chk("spur_state", dut.r_state, IDLE);
      chk("spur_q_after", q_m_access, 0);
      mem_lat = 20;
      @(negedge clk);
      dq.push_back(mk_d(19'h07777, 16'h0F0F, 1, 2'b11, 0));
      sb.push_back(mk_d(19'h07777, 16'h0F0F, 1, 2'b11, 0));
      n = 0;
      while (!q_m_access && n < 50) begin @(negedge clk); n++; end
      chk("rst_mid_granted", q_m_access, 1);
      @(posedge clk);
      #3;
      reset = 1;
      #1;
      chk("rst_mid_access", q_m_access, 0);
      chk("rst_mid_acks", {instr_m_ack, data_m_ack}, 0);
      chk("rst_mid_ctrl", {q_m_addr, q_m_wr_en, q_m_bytesel}, 0);
      repeat (3) @(posedge clk);
      #1;
      sb.delete();
      reset = 0;
      chk("rst_burst_cnt", dut.r_burst_cnt, 0);
      d_base = n_d_acks;
      i_base = n_i_acks;
      mem_lat = 0;
      @(negedge clk);
      dq.push_back(mk_d(19'h05555, 16'h3C3C, 0, 2'b01, 1));
      iq.push_back(mk_i(19'h06666));
      sb.push_back(mk_d(19'h05555, 16'h3C3C, 0, 2'b01, 1));
      sb.push_back(mk_i(19'h06666));
      wait_drain();
      chk("d_grant_count", dut.r_data_grants, n_d_acks - d_base);
      chk("i_grant_count", dut.r_instr_grants, n_i_acks - i_base);
      chk("d_acks_after_rst", n_d_acks - d_base, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Responder for the Core's two bus initiator ports: instruction fetch and data load/store/IO. It arbitrates both ports onto one shared memory/IO bus toward the external memory system. Data accesses win by default, because the Core stalls on load/store. A burst counter bounds how long instruction fetch can be starved. Each request is forwarded to the shared bus unchanged, and the shared-bus ack and read data are returned to the port that owns the grant.

## Interface
- `MAX_DATA_BURST`, default 4: consecutive data grants allowed while an instruction request waits. After that many, instruction gets the next grant. Legal range 1–15.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr_m_addr` in 19 [19:1]: fetch word address.
- `instr_m_access` in 1: fetch request; held until `instr_m_ack`.
- `instr_m_ack` out 1: one-cycle completion pulse.
- `instr_m_data_in` out 16: fetch read data; valid only when `instr_m_ack`=1, else 0.
- `data_m_addr` in 19 [19:1]: data word address.
- `data_m_data_out` in 16: write data from the Core.
- `data_m_access` in 1: data request; held until `data_m_ack`.
- `data_m_wr_en` in 1: 1 = write.
- `data_m_bytesel` in 2: byte lanes.
- `d_io` in 1: IO-space access.
- `data_m_ack` out 1: one-cycle completion pulse.
- `data_m_data_in` out 16: data read data; valid only with `data_m_ack`, else 0.
- `q_m_addr` out 19 [19:1]: shared bus address.
- `q_m_data_out` out 16: shared bus write data.
- `q_m_access` out 1: shared bus request.
- `q_m_wr_en` out 1: shared bus write enable.
- `q_m_bytesel` out 2: shared bus byte lanes.
- `q_io` out 1: shared bus IO-space select.
- `q_m_data_in` in 16: shared bus read data.
- `q_m_ack` in 1: shared bus completion pulse.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT_INSTR, GRANT_DATA: that port owns the shared bus until `q_m_ack`.
- IDLE transitions:
  - Only `data_m_access` set → GRANT_DATA.
  - Only `instr_m_access` set → GRANT_INSTR.
  - Both set → GRANT_DATA, unless `burst_cnt` == `MAX_DATA_BURST`; then GRANT_INSTR.
  - Neither set → stay in IDLE.
- GRANT_x transitions:
  - `q_m_ack`=1 → IDLE. The matching `x_m_ack` is asserted combinationally in the same cycle, and `x_m_data_in` = `q_m_data_in`.
  - Otherwise hold the state.
- Forwarding while in GRANT_x:
  - `q_m_access` = the granted port's access.
  - Address, wr_en, bytesel and io are routed combinationally from the granted port.
  - Instruction grants drive `q_m_wr_en`=0, `q_m_bytesel`=2'b11, `q_io`=0 and `q_m_data_out`=0.
- In IDLE, all `q_*` outputs are 0.
- `burst_cnt` (4 bits):
  - Incremented on entry to GRANT_DATA while `instr_m_access`=1, saturating at `MAX_DATA_BURST`.
  - Cleared on entry to GRANT_INSTR.
  - Cleared on any IDLE cycle with `instr_m_access`=0.
- Requester contract: the requester drops access at the same edge where it samples ack. The mandatory IDLE cycle after each completion therefore never re-grants a finished request.
- `q_m_ack` while in IDLE is ignored and produces no port ack.
- Reset (asynchronous, any time):
  - State → IDLE, `burst_cnt`=0.
  - All outputs return to 0 immediately.
  - An in-flight shared-bus transaction is abandoned. The downstream memory is reset from the same `reset`.

## Timing
- Reset values: all outputs 0.
- Grant latency: request seen in IDLE at edge N → GRANT at N+1 → `q_m_access` high during cycle N+1.
- Minimum transaction: 1 IDLE cycle + 1 GRANT cycle, when memory acks in the first grant cycle.
  - A back-to-back requester therefore sees at most one completion every 2 cycles.
- Ack path: `q_m_ack` → `x_m_ack` and `q_m_data_in` → `x_m_data_in` are combinational, with zero added latency.
- Address/control inputs must stay stable while access is high. The arbiter does not register them.
- Both ports requesting continuously with `MAX_DATA_BURST`=4: grant order D D D D I D D D D I …

## Structure
- Shared package holds:
  - the state enum `ArbState_t` {IDLE, GRANT_INSTR, GRANT_DATA};
  - the default-burst constant;
  - the instruction-grant constants: bytesel 2'b11, wr_en 0.
- Single flat module; no sub-module is needed. The burst counter is a few lines.
- Add a verilator-only counter of per-port grants for the bench.

## Test plan
- Lone fetch:
  - Stimulus: `instr_m_access`=1, addr 0x12345; memory acks 3 cycles after `q_m_access` with data 0xBEEF.
  - Required: `q_m_addr`=0x12345, `q_m_bytesel`=11; a single `instr_m_ack` pulse with `instr_m_data_in`=0xBEEF; `data_m_ack` stays 0.
- Data write:
  - Stimulus: addr 0x00400, data 0xA55A, bytesel 01, `d_io`=1, one-cycle memory ack.
  - Required: `q_m_wr_en`=1, `q_io`=1, `q_m_data_out`=0xA55A, `q_m_bytesel`=01; `data_m_ack` 2 cycles after the request rises.
- Simultaneous requests:
  - Stimulus: both ports assert in the same cycle.
  - Required: data granted first; fetch granted after the IDLE gap; each port gets exactly one ack.
- Starvation bound:
  - Stimulus: `data_m_access` continuously re-asserted and `instr_m_access` held, `MAX_DATA_BURST`=4.
  - Required: exactly 4 data acks, then 1 instruction ack; pattern repeats.
- Spurious ack:
  - Stimulus: `q_m_ack`=1 while in IDLE.
  - Required: no port ack; state unchanged.
- Reset mid-transaction:
  - Stimulus: assert `reset` while in GRANT_DATA, asynchronously between edges.
  - Required: `q_m_access` and all acks drop to 0 before the next edge; after release, the first request is granted normally with `burst_cnt`=0.
